wash_phase_seq: RTL

//  Wash-program sequencer sitting directly downstream of the decade counter (counter10).

---
 rtl/wash_phase_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/wash_phase_seq.sv
// Wash-program sequencer driven by the decade counter (counter10) time base.
// Each 9->0 rollover of Q_in is one time unit.
// The program runs IDLE->FILL->WASH->DRAIN->SPIN->DONE.
// Each phase counts its duration down in 2-digit BCD.
// Optional feature macro: SOAK_PHASE_EN inserts a SOAK phase between FILL and WASH.
// All outputs are registered. They are loaded from the next state and the next hold value,
// so they always match the registered state and hold seen on the same cycle.

module wash_phase_seq #(
    parameter logic [7:0] FILL_T  = 8'h05,
    parameter logic [7:0] WASH_T  = 8'h20,
    parameter logic [7:0] DRAIN_T = 8'h05,
    parameter logic [7:0] SPIN_T  = 8'h10,
    parameter logic [7:0] SOAK_T  = 8'h15
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       start,
    input  logic       pause,
    input  logic       lid_open,
    input  logic [3:0] Q_in,
    output logic       EN,
    output logic [2:0] state,
    output logic [7:0] remain,
    output logic       valve,
    output logic       motor,
    output logic       pump,
    output logic       spin_hi,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFill  = 3'd1,
        StSoak  = 3'd2,
        StWash  = 3'd3,
        StDrain = 3'd4,
        StSpin  = 3'd5,
        StDone  = 3'd6
    } phase_e;

    phase_e     state_q, state_d;
    logic [7:0] remain_q, remain_d;
    logic       hold_q, hold_d;
    logic [3:0] q_prev_q;
    logic       tick;
    logic       run_d;
    logic       en_d, valve_d, motor_d, pump_d, spin_hi_d, done_d;

`ifndef SOAK_PHASE_EN
    // SOAK_T has no use without the soak phase.
    logic unused_soak_t;
    assign unused_soak_t = ^SOAK_T;
`endif

    // BCD decrement; 00 wraps to 99 so an illegal zero duration lasts 100 ticks.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd0) begin
            ones = 4'd9;
            tens = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
        end else begin
            ones = ones - 4'd1;
        end
        return {tens, ones};
    endfunction

    // Time-base tick and next-state / next-remaining computation.
    always_comb begin
        tick     = (q_prev_q == 4'd9) && (Q_in == 4'd0);
        hold_d   = pause | lid_open;
        state_d  = state_q;
        remain_d = remain_q;
        unique case (state_q)
            StIdle: begin
                if (start && !lid_open) begin
                    state_d  = StFill;
                    remain_d = FILL_T;
                end
            end
            StFill, StSoak, StWash, StDrain, StSpin: begin
                // A tick seen while hold is set is dropped, not deferred.
                if (tick && !hold_q) begin
                    if (remain_q == 8'h01) begin
                        unique case (state_q)
                            StFill: begin
`ifdef SOAK_PHASE_EN
                                state_d  = StSoak;
                                remain_d = SOAK_T;
`else
                                state_d  = StWash;
                                remain_d = WASH_T;
`endif
                            end
                            StSoak: begin
                                state_d  = StWash;
                                remain_d = WASH_T;
                            end
                            StWash: begin
                                state_d  = StDrain;
                                remain_d = DRAIN_T;
                            end
                            StDrain: begin
                                state_d  = StSpin;
                                remain_d = SPIN_T;
                            end
                            default: begin
                                state_d  = StDone;
                                remain_d = 8'h00;
                            end
                        endcase
                    end else begin
                        remain_d = bcd_dec(remain_q);
                    end
                end
            end
            StDone: begin
                if (lid_open) begin
                    state_d  = StIdle;
                    remain_d = 8'h00;
                end else if (start) begin
                    state_d  = StFill;
                    remain_d = FILL_T;
                end
            end
            default: begin
                state_d  = StIdle;
                remain_d = 8'h00;
            end
        endcase
    end

    // Output decode from the next state, gated by the next hold value.
    always_comb begin
        run_d     = 1'b0;
        en_d      = 1'b0;
        valve_d   = 1'b0;
        motor_d   = 1'b0;
        pump_d    = 1'b0;
        spin_hi_d = 1'b0;
        done_d    = (state_d == StDone);
        unique case (state_d)
            StFill, StSoak, StWash, StDrain, StSpin: run_d = !hold_d;
            default:                                 run_d = 1'b0;
        endcase
        en_d = run_d;
        unique case (state_d)
            StFill:  valve_d = run_d;
            StWash:  motor_d = run_d;
            StDrain: pump_d  = run_d;
            StSpin: begin
                motor_d   = run_d;
                pump_d    = run_d;
                spin_hi_d = run_d;
            end
            default: ;
        endcase
    end

    // Sequencer state, hold, counter history and registered outputs.
    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            state_q  <= StIdle;
            remain_q <= 8'h00;
            hold_q   <= 1'b0;
            q_prev_q <= 4'd0;
            EN       <= 1'b0;
            valve    <= 1'b0;
            motor    <= 1'b0;
            pump     <= 1'b0;
            spin_hi  <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            hold_q   <= hold_d;
            q_prev_q <= Q_in;
            EN       <= en_d;
            valve    <= valve_d;
            motor    <= motor_d;
            pump     <= pump_d;
            spin_hi  <= spin_hi_d;
            done     <= done_d;
        end
    end

    assign state  = state_q;
    assign remain = remain_q;

endmodule
